// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: mode encodings, default timing
// and the pixel-path latency that downstream overlay stages align against.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_FILL  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int PIX_LAT = 3;

    // Minimum result of 1 so a degenerate depth still yields a legal port width.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port frame-buffer RAM with synchronous read; contents survive reset.
module fb_ram
    import vga_pkg::*;
#(
    parameter  int DEPTH  = 38400,
    parameter  int WIDTH  = 3,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_addr_ok;

    // Addresses past the end are legal on the bus but never touch storage.
    assign w_addr_ok = {1'b0, i_addr} < (ADDR_W + 1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                if (w_addr_ok) begin
                    r_mem[i_addr] <= i_wdata;
                end
            end else if (w_addr_ok) begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/vga_fb_pixel_gen.sv
// Pixel generator between vga_sync and the pins: frame buffer or test pattern,
// three-stage registered path with syncs and frame_start delayed to match.
module vga_fb_pixel_gen
    import vga_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_DEF,
    parameter  int V_ACTIVE = V_ACTIVE_DEF,
    parameter  int X_SHIFT  = 1,
    parameter  int Y_SHIFT  = 2,
    parameter  int RGB_W    = 3,
    parameter  bit SYNC_POL = 1'b0,
    localparam int FB_W     = H_ACTIVE >> X_SHIFT,
    localparam int FB_H     = V_ACTIVE >> Y_SHIFT,
    localparam int FB_DEPTH = FB_W * FB_H,
    localparam int ADDR_W   = clog2(FB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        mode,
    input  logic [RGB_W-1:0]  fill_color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    output logic [RGB_W-1:0]  rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int         C         = RGB_W / 3;
    localparam logic       SYNC_IDLE = ~SYNC_POL;
    localparam logic [9:0] BAR_W     = 10'(H_ACTIVE / 8);

    mode_t r_act_mode;

    logic       r1_valid, r1_von, r1_hs, r1_vs, r1_first;
    logic [9:0] r1_col, r1_row;
    logic [2:0] r1_bar;

    logic       r2_valid, r2_show, r2_hs, r2_vs, r2_first;
    logic [2:0] r2_bar;

    logic [9:0]        w_bar;
    logic              w_origin;
    logic              w_in_range;
    logic              w_rd_en;
    logic              w_wr_fire;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [RGB_W-1:0]  w_fb_rdata;

    assign w_bar    = pixel_x / BAR_W;
    assign w_origin = (pixel_x == '0) && (pixel_y == '0);

    assign w_in_range = ({1'b0, r1_col} < 11'(FB_W)) && ({1'b0, r1_row} < 11'(FB_H));
    assign w_rd_en    = r1_valid && r1_von && w_in_range;
    assign w_rd_addr  = ADDR_W'(r1_row) * ADDR_W'(FB_W) + ADDR_W'(r1_col);

    // The RAM port belongs to the display whenever S1 holds an active pixel,
    // so reads and writes can never collide.
    assign wr_ready   = ~reset & ~r1_von;
    assign w_wr_fire  = wr_valid & wr_ready;
    assign w_ram_addr = w_wr_fire ? wr_addr : w_rd_addr;

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (RGB_W)
    ) u_fb_ram (
        .clk     (clk),
        .i_en    (w_rd_en | w_wr_fire),
        .i_we    (w_wr_fire),
        .i_addr  (w_ram_addr),
        .i_wdata (wr_data),
        .o_rdata (w_fb_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_mode  <= MODE_BLANK;
            r1_valid    <= 1'b0;
            r1_von      <= 1'b0;
            r1_hs       <= SYNC_IDLE;
            r1_vs       <= SYNC_IDLE;
            r1_first    <= 1'b0;
            r1_col      <= '0;
            r1_row      <= '0;
            r1_bar      <= '0;
            r2_valid    <= 1'b0;
            r2_show     <= 1'b0;
            r2_hs       <= SYNC_IDLE;
            r2_vs       <= SYNC_IDLE;
            r2_first    <= 1'b0;
            r2_bar      <= '0;
            rgb         <= '0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            // Latching at the input-side origin means the new mode reaches S3
            // exactly when pixel (0,0) does, so no frame is ever mixed.
            if (w_origin) begin
                r_act_mode <= mode_t'(mode);
            end

            r1_valid <= 1'b1;
            r1_von   <= video_on;
            r1_hs    <= hsync_in;
            r1_vs    <= vsync_in;
            r1_first <= w_origin;
            r1_col   <= pixel_x >> X_SHIFT;
            r1_row   <= pixel_y >> Y_SHIFT;
            r1_bar   <= (w_bar > 10'd7) ? 3'd7 : w_bar[2:0];

            r2_valid <= r1_valid;
            r2_show  <= w_rd_en;
            r2_hs    <= r1_hs;
            r2_vs    <= r1_vs;
            r2_first <= r1_first;
            r2_bar   <= r1_bar;

            hsync       <= r2_hs;
            vsync       <= r2_vs;
            frame_start <= r2_valid & r2_first;

            if (!r2_valid || !r2_show) begin
                rgb <= '0;
            end else begin
                case (r_act_mode)
                    MODE_FB:    rgb <= w_fb_rdata;
                    MODE_BARS:  rgb <= {{C{r2_bar[2]}}, {C{r2_bar[1]}}, {C{r2_bar[0]}}};
                    MODE_FILL:  rgb <= fill_color;
                    MODE_BLANK: rgb <= '0;
                    default:    rgb <= '0;
                endcase
            end
        end
    end

endmodule
